// File: rtl/bus_arbiter_resp_pkg.sv
// Shared types and constants for the request/grant bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANTED = 2'd2,
    OWNED   = 2'd3
  } arb_state_t;

  localparam int GNT_DLY_MIN = 2;
  localparam int GNT_DLY_MAX = 5;

  // Number of bits needed to hold max_val (at least one).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/bus_arbiter_resp_sig_edge_det.sv
// Registers a single-bit input and reports its rising and falling edges.
module sig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/bus_arbiter_resp.sv
// Single-requester arbiter: delayed grant on request rise, ownership tracking
// via frame/irdy, and grant retraction on transaction end or timeout.
module bus_arbiter_resp
  import bus_arb_pkg::*;
#(
  parameter int GNT_DLY = 3,
  parameter int TMO_CYC = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request,
  input  logic             frame,
  input  logic             irdy,
  output logic             grant,
  output logic             busy,
  output logic             tmo_err,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int DLY_W = cnt_width(GNT_DLY - 1);
  localparam int TMO_W = cnt_width(TMO_CYC - 1);

  generate
    if (GNT_DLY < GNT_DLY_MIN || GNT_DLY > GNT_DLY_MAX) begin : g_bad_dly
      $error("bus_arbiter_resp: GNT_DLY out of range");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
      $error("bus_arbiter_resp: TMO_CYC must be at least 1");
    end
  endgenerate

  logic req_rise, req_fall;
  logic frm_rise, frm_fall;
  logic irdy_rise, irdy_fall;

  sig_edge_det u_req_edge  (.clk(clk), .rst(rst), .sig(request), .rise(req_rise),  .fall(req_fall));
  sig_edge_det u_frm_edge  (.clk(clk), .rst(rst), .sig(frame),   .rise(frm_rise),  .fall(frm_fall));
  sig_edge_det u_irdy_edge (.clk(clk), .rst(rst), .sig(irdy),    .rise(irdy_rise), .fall(irdy_fall));

  logic unused_falls;
  assign unused_falls = ^{req_fall, frm_fall, irdy_fall};

  logic end_cond;
  assign end_cond = frm_rise & irdy_rise;

  arb_state_t       state_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [CNT_W-1:0] txn_cnt_q;
  logic             grant_q, busy_q, tmo_err_q;
  // A request already high when reset lifts must be seen low before a rise counts.
  logic             armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      tmo_cnt_q <= '0;
      txn_cnt_q <= '0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      armed_q   <= armed_q | ~request;
      case (state_q)
        IDLE: begin
          if (req_rise && armed_q) begin
            dly_cnt_q <= DLY_W'(GNT_DLY - 1);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (!request) begin
            state_q <= IDLE;
          end else if (dly_cnt_q == '0) begin
            grant_q   <= 1'b1;
            tmo_cnt_q <= TMO_W'(TMO_CYC - 1);
            state_q   <= GRANTED;
          end else begin
            dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          end
        end
        GRANTED: begin
          if (!frame) begin
            busy_q  <= 1'b1;
            state_q <= OWNED;
          end else if (tmo_cnt_q == '0) begin
            grant_q   <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
          end
        end
        OWNED: begin
          if (end_cond) begin
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            txn_cnt_q <= txn_cnt_q + CNT_W'(1);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign tmo_err = tmo_err_q;
  assign txn_cnt = txn_cnt_q;

endmodule
